// File: rtl/qsys_traffic_sequencer.sv
// -----------------------------------------------------------------------------
// qsys_traffic_sequencer
//   Avalon-MM controlled two-way traffic light sequencer with pedestrian walk
//   requests and a "cycle restarted" interrupt.
//
//   Ports
//     clk         system clock, all logic on the rising edge
//     reset_n     asynchronous active-low reset
//     address     register select (0 CONTROL, 1 GREEN, 2 YELLOW, 3 ALLRED,
//                 4 PRESCALE, 5 STATUS, 6-7 read as zero)
//     chipselect  bus select; a write happens when chipselect=1 and write_n=0
//     write_n     active-low write strobe
//     writedata   write data
//     readdata    combinational read data, zero wait states
//     ped_ns      asynchronous NS pedestrian button, active high
//     ped_ew      asynchronous EW pedestrian button, active high
//     out_port    registered lamp drive: [0]NS red [1]NS yellow [2]NS green
//                 [3]EW red [4]EW yellow [5]EW green [6]NS walk [7]EW walk
//     irq         level interrupt, irq_flag AND irq_en
// -----------------------------------------------------------------------------
module qsys_traffic_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ped_ns,
  input  logic        ped_ew,
  output logic [17:0] out_port,
  output logic        irq
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    AR1  = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5,
    AR2  = 3'd6
  } state_t;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic        ctrl_enable;
  logic        ctrl_ped_en;
  logic        ctrl_irq_en;
  logic [23:0] green_ticks;
  logic [23:0] yellow_ticks;
  logic [23:0] allred_ticks;
  logic [15:0] prescale;

  logic wr;
  assign wr = chipselect && !write_n;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable  <= 1'b0;
      ctrl_ped_en  <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      green_ticks  <= 24'd10;
      yellow_ticks <= 24'd3;
      allred_ticks <= 24'd1;
      prescale     <= 16'd0;
    end else if (wr) begin
      case (address)
        3'd0: begin
          ctrl_enable <= writedata[0];
          ctrl_ped_en <= writedata[1];
          ctrl_irq_en <= writedata[2];
        end
        3'd1:    green_ticks  <= writedata[23:0];
        3'd2:    yellow_ticks <= writedata[23:0];
        3'd3:    allred_ticks <= writedata[23:0];
        3'd4:    prescale     <= writedata[15:0];
        default: ;
      endcase
    end
  end

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata[31:24]};

  // ---------------------------------------------------------------------------
  // Tick prescaler: one-cycle tick every prescale+1 clocks while enabled.
  // ---------------------------------------------------------------------------
  logic [15:0] presc_cnt;
  logic        tick;

  assign tick = ctrl_enable && (presc_cnt == prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         presc_cnt <= 16'd0;
    else if (!ctrl_enable) presc_cnt <= 16'd0;
    else if (tick)         presc_cnt <= 16'd0;
    else                   presc_cnt <= presc_cnt + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // Pedestrian synchronizers and rising-edge request latches
  // ---------------------------------------------------------------------------
  logic [2:0] ns_sync, ew_sync;   // [0],[1] synchronizer, [2] edge history
  logic       ns_rise, ew_rise;
  logic       ns_req, ew_req;
  logic       ns_clr, ew_clr;

  assign ns_rise = ns_sync[1] && !ns_sync[2];
  assign ew_rise = ew_sync[1] && !ew_sync[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ns_sync <= 3'b000;
      ew_sync <= 3'b000;
      ns_req  <= 1'b0;
      ew_req  <= 1'b0;
    end else begin
      ns_sync <= {ns_sync[1:0], ped_ns};
      ew_sync <= {ew_sync[1:0], ped_ew};
      // A fresh edge arriving on the clearing entry keeps the request alive.
      ns_req  <= ns_rise || (ns_req && !ns_clr);
      ew_req  <= ew_rise || (ew_req && !ew_clr);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t      state, next_state;
  logic [23:0] dwell, next_dwell;
  logic        walk_ns, walk_ew, next_walk_ns, next_walk_ew;
  logic        enter_ns_g, enter_ew_g;

  function automatic logic [23:0] dwell_for(state_t s, logic [23:0] g,
                                            logic [23:0] y, logic [23:0] a);
    logic [23:0] d;
    case (s)
      NS_G, EW_G: d = g;
      NS_Y, EW_Y: d = y;
      default:    d = a;
    endcase
    return (d == 24'd0) ? 24'd1 : d;
  endfunction

  function automatic state_t succ(state_t s);
    case (s)
      NS_G:    return NS_Y;
      NS_Y:    return AR1;
      AR1:     return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR2;
      default: return NS_G;   // AR2 and IDLE both continue into NS_G
    endcase
  endfunction

  function automatic logic [17:0] lamp_for(state_t s, logic wns, logic wew);
    logic [17:0] l;
    case (s)
      NS_G:    l = 18'h00C;
      NS_Y:    l = 18'h00A;
      EW_G:    l = 18'h021;
      EW_Y:    l = 18'h011;
      default: l = 18'h009;   // IDLE and both all-red phases
    endcase
    l[6] = wns;
    l[7] = wew;
    return l;
  endfunction

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state   = state;
    next_dwell   = dwell;
    next_walk_ns = walk_ns;
    next_walk_ew = walk_ew;

    if (!ctrl_enable) begin
      next_state = IDLE;
    end else if (state == IDLE || (tick && dwell <= 24'd1)) begin
      next_state = succ(state);
    end else if (tick) begin
      next_dwell = dwell - 24'd1;
    end

    // Every transition changes state, so a difference marks a state entry.
    if (next_state != state && next_state != IDLE)
      next_dwell = dwell_for(next_state, green_ticks, yellow_ticks, allred_ticks);

    enter_ns_g = (next_state == NS_G) && (state != NS_G);
    enter_ew_g = (next_state == EW_G) && (state != EW_G);
    ns_clr     = enter_ns_g && ctrl_ped_en && ns_req;
    ew_clr     = enter_ew_g && ctrl_ped_en && ew_req;

    // Walk is decided once at green entry and held for the whole green.
    if (next_state != NS_G) next_walk_ns = 1'b0;
    else if (enter_ns_g)    next_walk_ns = ns_clr;
    if (next_state != EW_G) next_walk_ew = 1'b0;
    else if (enter_ew_g)    next_walk_ew = ew_clr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dwell    <= 24'd0;
      walk_ns  <= 1'b0;
      walk_ew  <= 1'b0;
      out_port <= 18'h009;
    end else begin
      state    <= next_state;
      dwell    <= next_dwell;
      walk_ns  <= next_walk_ns;
      walk_ew  <= next_walk_ew;
      out_port <= lamp_for(next_state, next_walk_ns, next_walk_ew);
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt flag: set on every NS_G entry, set beats a same-cycle clear.
  // ---------------------------------------------------------------------------
  logic irq_flag;
  logic irq_clr;

  assign irq_clr = wr && (address == 3'd5) && writedata[8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_flag <= 1'b0;
    else          irq_flag <= enter_ns_g || (irq_flag && !irq_clr);
  end

  assign irq = irq_flag && ctrl_irq_en;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0: readdata = {29'd0, ctrl_irq_en, ctrl_ped_en, ctrl_enable};
      3'd1: readdata = {8'd0, green_ticks};
      3'd2: readdata = {8'd0, yellow_ticks};
      3'd3: readdata = {8'd0, allred_ticks};
      3'd4: readdata = {16'd0, prescale};
      3'd5: readdata = {23'd0, irq_flag, 2'b00, ew_req, ns_req, 1'b0, state};
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_qsys_traffic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_qsys_traffic_sequencer
//   Self-checking bench: a behavioural model of the sequencer (phase number,
//   remaining ticks, request bits, register shadow) is stepped on each clock
//   edge and compared against the DUT on every falling edge. Directed scenarios
//   pin the model with literal phase lengths and lamp values; a randomized
//   phase then exercises register writes and pedestrian buttons.
// -----------------------------------------------------------------------------
module tb_qsys_traffic_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        ped_ns = 1'b0;
  logic        ped_ew = 1'b0;
  logic [17:0] out_port;
  logic        irq;

  always #5 clk = ~clk;

  qsys_traffic_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .ped_ns     (ped_ns),
    .ped_ew     (ped_ew),
    .out_port   (out_port),
    .irq        (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   phase 0 = IDLE, 1..6 = NS_G, NS_Y, AR1, EW_G, EW_Y, AR2
  //   direction index 0 = NS, 1 = EW
  // ---------------------------------------------------------------------------
  int unsigned lamp_tbl [7] = '{32'h009, 32'h00C, 32'h00A, 32'h009,
                                32'h021, 32'h011, 32'h009};
  int          m_phase;
  int unsigned m_left;          // ticks left in the current phase
  int unsigned m_pcnt;
  bit [2:0]    m_ctrl;
  int unsigned m_dur [3];       // green, yellow, all-red
  int unsigned m_pre;
  bit          m_walk [2];
  bit          m_pipe [2][3];   // two sync stages plus previous value
  bit          m_req  [2];
  bit          m_irqf;

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    m_pcnt  = 0;
    m_ctrl  = 3'b000;
    m_dur   = '{10, 3, 1};
    m_pre   = 0;
    m_irqf  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_walk[d] = 1'b0;
      m_req[d]  = 1'b0;
      for (int k = 0; k < 3; k++) m_pipe[d][k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit en      = m_ctrl[0];
    bit ped_en  = m_ctrl[1];
    bit tick    = en && (m_pcnt == m_pre);
    bit wr      = chipselect && !write_n;
    bit rise [2];
    bit clr  [2];
    bit irq_set = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rise[d] = m_pipe[d][1] && !m_pipe[d][2];
      clr[d]  = 1'b0;
    end

    if (!en) begin
      m_phase = 0;
      m_walk  = '{1'b0, 1'b0};
    end else if (m_phase == 0 || (tick && m_left <= 1)) begin
      m_phase = (m_phase % 6) + 1;
      m_left  = m_dur[(m_phase - 1) % 3];
      if (m_left == 0) m_left = 1;
      m_walk  = '{1'b0, 1'b0};
      if (m_phase == 1 || m_phase == 4) begin
        int d = (m_phase == 1) ? 0 : 1;
        if (ped_en && m_req[d]) begin
          m_walk[d] = 1'b1;
          clr[d]    = 1'b1;
        end
      end
      if (m_phase == 1) irq_set = 1'b1;
    end else if (tick) begin
      m_left--;
    end

    m_pcnt = (!en || tick) ? 0 : ((m_pcnt + 1) & 32'hFFFF);

    for (int d = 0; d < 2; d++) begin
      m_req[d]     = rise[d] || (m_req[d] && !clr[d]);
      m_pipe[d][2] = m_pipe[d][1];
      m_pipe[d][1] = m_pipe[d][0];
    end
    m_pipe[0][0] = ped_ns;
    m_pipe[1][0] = ped_ew;

    m_irqf = irq_set || (m_irqf && !(wr && address == 3'd5 && writedata[8]));

    if (wr) begin
      case (address)
        3'd0: m_ctrl = writedata[2:0];
        3'd1, 3'd2, 3'd3: m_dur[address - 1] = writedata[23:0];
        3'd4: m_pre = writedata[15:0];
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] exp_out();
    return lamp_tbl[m_phase] | (32'(m_walk[0]) << 6) | (32'(m_walk[1]) << 7);
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    case (a)
      3'd0: return {29'd0, m_ctrl};
      3'd1: return m_dur[0] & 32'hFF_FFFF;
      3'd2: return m_dur[1] & 32'hFF_FFFF;
      3'd3: return m_dur[2] & 32'hFF_FFFF;
      3'd4: return m_pre & 32'hFFFF;
      3'd5: return 32'(m_phase) | (32'(m_req[0]) << 4) | (32'(m_req[1]) << 5)
                   | (32'(m_irqf) << 8);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (reset_n) begin
      check("out_port", 32'(out_port), exp_out());
      check("irq", 32'(irq), 32'(m_irqf && m_ctrl[2]));
      check("readdata", readdata, exp_read(address));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    #1;
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    ped_ns = 1'b0;
    ped_ew = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Waits on falling edges until out_port shows p; returns at that edge.
  task automatic wait_out(input logic [17:0] p);
    int n = 0;
    while (out_port !== p && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_for_lamp", 32'(out_port), 32'(p));
  endtask

  // Length in clocks of the next run of out_port == p.
  task automatic run_len(input logic [17:0] p, output int len);
    wait_out(p);
    len = 0;
    while (out_port === p && len < 1000) begin
      len++;
      @(negedge clk);
    end
  endtask

  int len;

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("reset_out_port", 32'(out_port), 32'h009);
    check("reset_irq", 32'(irq), 32'd0);
    #1 reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      logic [31:0] dflt [8] = '{32'd0, 32'd10, 32'd3, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
      @(negedge clk);
      #1 address = 3'(a);
      #1 check("reset_reg", readdata, dflt[a]);
    end

    // ---------------- default sequence, PRESCALE=0 ----------------
    bus_write(3'd0, 32'h1);
    run_len(18'h00C, len); check("ns_g_len", len, 10);
    run_len(18'h00A, len); check("ns_y_len", len, 3);
    run_len(18'h009, len); check("ar1_len", len, 1);
    run_len(18'h021, len); check("ew_g_len", len, 10);
    run_len(18'h011, len); check("ew_y_len", len, 3);
    run_len(18'h009, len); check("ar2_len", len, 1);
    check("back_to_ns_g", 32'(out_port), 32'h00C);

    // ---------------- prescaler ----------------
    do_reset();
    bus_write(3'd4, 32'd4);
    bus_write(3'd1, 32'hFF00_0002);   // upper bits must be dropped
    bus_write(3'd0, 32'h1);
    run_len(18'h00C, len);            // first green starts off a tick boundary
    run_len(18'h00C, len); check("presc_green2_len", len, 10);
    bus_write(3'd1, 32'd0);
    run_len(18'h00C, len); check("presc_green0_len", len, 5);

    // ---------------- pedestrian walk ----------------
    do_reset();
    bus_write(3'd0, 32'h3);
    wait_out(18'h00C);
    #1 ped_ew = 1'b1;
    repeat (3) @(negedge clk);
    #1 ped_ew = 1'b0;
    address = 3'd5;
    repeat (3) @(negedge clk);
    check("ped_ew_req_set", readdata[5], 32'd1);
    run_len(18'h0A1, len); check("ew_walk_len", len, 10);
    check("ped_ew_req_cleared", readdata[5], 32'd0);
    run_len(18'h021, len); check("ew_no_walk_len", len, 10);

    // ---------------- interrupt ----------------
    do_reset();
    bus_write(3'd0, 32'h5);
    wait_out(18'h00C);
    #1 check("irq_rise", 32'(irq), 32'd1);
    @(negedge clk);
    bus_write(3'd5, 32'h100);
    check("irq_clear", 32'(irq), 32'd0);
    run_len(18'h011, len);            // returns during the one-clock AR2
    bus_write(3'd5, 32'h100);         // clear lands on the NS_G entry edge
    check("irq_set_wins_lamp", 32'(out_port), 32'h00C);
    check("irq_set_wins", 32'(irq), 32'd1);

    // ---------------- disable and mid-sequence reset ----------------
    bus_write(3'd0, 32'h1);
    wait_out(18'h011);
    bus_write(3'd0, 32'h0);
    check("disable_latency", 32'(out_port), 32'h011);
    @(negedge clk);
    check("disable_idle", 32'(out_port), 32'h009);
    bus_write(3'd0, 32'h1);
    wait_out(18'h021);
    #2 reset_n = 1'b0;
    #1 check("async_reset_out", 32'(out_port), 32'h009);
    address = 3'd0;
    #1 check("async_reset_ctrl", readdata, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // ---------------- randomized traffic ----------------
    bus_write(3'd4, 32'd1);
    bus_write(3'd0, 32'h7);
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd0;
        writedata  = {$urandom_range(0, 9) == 0 ? 31'd0 : 31'(($urandom & 32'h6) >> 1),
                      ($urandom_range(0, 9) != 0)};
      end else if (r < 10) begin
        chipselect = 1'b1; write_n = 1'b0;
        address    = 3'($urandom_range(1, 3));
        writedata  = {8'($urandom), 24'($urandom_range(0, 4))};
      end else if (r < 13) begin
        chipselect = 1'b1; write_n = 1'b0; address = 3'd5;
        writedata  = $urandom;
      end else if (r < 16) begin
        chipselect = 1'b0; write_n = 1'b0;   // strobe without select: ignored
        address    = 3'($urandom_range(0, 7));
        writedata  = $urandom;
      end else begin
        address = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 19) == 0) ped_ns = ~ped_ns;
      if ($urandom_range(0, 19) == 0) ped_ew = ~ped_ew;
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qsys_traffic_sequencer.md
QSYS_TRAFFIC_SEQUENCER -- requirements
Module: qsys_traffic_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: address  in  3  Avalon-MM register select.
REQ-004 SHALL have ports: chipselect  in  1, write_n  in  1 (active low), writedata  in  32.
REQ-005 SHALL have ports: readdata  out  32  combinational read mux, zero wait states.
REQ-006 SHALL have ports: ped_ns, ped_ew  in  1 each  asynchronous pedestrian buttons, active high.
REQ-007 SHALL have ports: out_port  out  18  lamp drive to red LED bank; irq  out  1  level interrupt.
REQ-008 SHALL have registers (addr, reset default, meaning): 0 CONTROL 0x0 [0]enable [1]ped_en [2]irq_en; 1 GREEN 10 [23:0] ticks; 2 YELLOW 3 [23:0]; 3 ALLRED 1 [23:0]; 4 PRESCALE 0 [15:0]; 5 STATUS ro [2:0]state [4]ped_ns_req [5]ped_ew_req [8]irq_flag; addresses 6-7 read 0.

Function
REQ-009 SHALL write a register when chipselect=1 and write_n=0, taking effect next cycle; unused bits read 0.
REQ-010 SHALL clear irq_flag on write to address 5 with writedata[8]=1; other STATUS bits not writable.
REQ-011 SHALL generate tick one cycle wide when 16-bit prescale counter equals PRESCALE, counter then returns to 0; tick period PRESCALE+1 clocks; counter held at 0 while enable=0.
REQ-012 SHALL implement states IDLE(0), NS_G(1), NS_Y(2), AR1(3), EW_G(4), EW_Y(5), AR2(6); cycle NS_G->NS_Y->AR1->EW_G->EW_Y->AR2->NS_G.
REQ-013 SHALL load dwell counter with state duration (GREEN/YELLOW/ALLRED) on state entry, duration 0 treated as 1; on tick, if counter<=1 transition, else decrement; dwell = max(duration,1) ticks.
REQ-014 SHALL move IDLE->NS_G on the cycle after enable reads 1; the register value at entry is used for the dwell.
REQ-015 SHALL move any state->IDLE on the cycle after enable reads 0, overriding dwell; walk outputs cleared.
REQ-016 SHALL drive out_port: [0]NS red [1]NS yellow [2]NS green [3]EW red [4]EW yellow [5]EW green [6]NS walk [7]EW walk [17:8]=0; registered, changes with state.
REQ-017 SHALL show red for a direction in every state where it is not green/yellow; IDLE drives 0x009.
REQ-018 SHALL pass ped_ns/ped_ew through two-flop synchronizers, then latch rising edges into ped_ns_req/ped_ew_req.
REQ-019 SHALL, when ped_en=1, set NS walk for the whole NS_G if ped_ns_req=1 at NS_G entry and clear ped_ns_req at that entry; EW symmetric with EW_G.
REQ-020 SHALL keep request set if a new synchronized edge coincides with the clearing entry (set wins).
REQ-021 SHALL retain requests when ped_en=0 or in IDLE; no walk shown.
REQ-022 SHALL set irq_flag on each entry into NS_G; set wins over simultaneous clear; irq = irq_flag AND irq_en.
REQ-023 SHALL apply mid-state writes to GREEN/YELLOW/ALLRED only at the next entry of the affected state.

Reset
REQ-024 SHALL on reset_n=0 asynchronously force: registers to REQ-008 defaults, state IDLE, out_port=0x009, irq=0, readdata per defaults, prescale/dwell counters 0, requests and synchronizers 0.
REQ-025 SHALL resume from IDLE after reset release; reset mid-cycle abandons the sequence with no partial output.

Verification
REQ-026 Defaults, PRESCALE=0, write CONTROL=1 -> NS_G (0x00C) 10 clk, NS_Y (0x00A) 3, AR1 (0x009) 1, EW_G (0x021) 10, EW_Y (0x011) 3, AR2 1, back to NS_G.
REQ-027 PRESCALE=4, GREEN=2 -> NS_G lasts 10 clocks; GREEN=0 -> 5 clocks.
REQ-028 ped_en=1, pulse ped_ew high 3 clocks during NS_G -> STATUS[5]=1; next EW_G out_port=0x0A1, STATUS[5] clears at EW_G entry; following EW_G shows 0x021.
REQ-029 irq_en=1 -> irq rises at NS_G entry; write STATUS 0x100 -> irq low next cycle; clear on same cycle as NS_G entry -> irq stays 1.
REQ-030 CONTROL=0 during EW_Y -> next cycle IDLE, out_port=0x009; reset_n pulse during EW_G -> out_port=0x009 immediately, CONTROL reads 0.
